// File: rtl/delay_cy_pkg.sv
// delay_cy_pkg
// Shared defaults and helpers for the multi-channel cycle delay line.
//   DEF_NCH / DEF_DLY_W / DEF_EDGE_DEPTH : default channel count, delay width,
//                                          edge queue depth
//   PTR_W                                : queue pointer width for the default depth
//   eff_delay()                          : a programmed delay of 0 behaves as 1
//   target_add()                         : output-edge timestamp for a new input edge
// Helpers work on a wide CALC_W word; callers cast the result to their own
// width, which also gives the modulo-2^DLY_W wrap of the timestamp.
package delay_cy_pkg;

  localparam int DEF_NCH        = 4;
  localparam int DEF_DLY_W      = 16;
  localparam int DEF_EDGE_DEPTH = 4;
  localparam int PTR_W          = $clog2(DEF_EDGE_DEPTH);
  localparam int CALC_W         = 32;

  function automatic logic [CALC_W-1:0] eff_delay(input logic [CALC_W-1:0] cfg);
    return (cfg == '0) ? CALC_W'(1) : cfg;
  endfunction

  function automatic logic [CALC_W-1:0] target_add(input logic [CALC_W-1:0] ts,
                                                   input logic [CALC_W-1:0] dly);
    return ts + dly;
  endfunction

endpackage

// File: rtl/delay_cy_chan.sv
// delay_cy_chan
// One channel of the delay line: 3-stage synchroniser, edge detect, queue of
// output-edge timestamps, latched delay, sticky overflow and toggling output.
//   clk, rst    : clock, synchronous active-high reset
//   sig_in      : asynchronous input waveform
//   ch_en       : channel enable (0 flushes the queue and forces sig_out low)
//   delay_cfg   : requested delay in cycles
//   ts          : shared free-running timestamp
//   ovf_clr     : write-1-to-clear for ovf
//   sig_out     : delayed waveform
//   busy        : queue non-empty
//   ovf         : sticky overflow flag
module delay_cy_chan
  import delay_cy_pkg::*;
#(
  parameter int DLY_W      = DEF_DLY_W,
  parameter int EDGE_DEPTH = DEF_EDGE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             ch_en,
  input  logic [DLY_W-1:0] delay_cfg,
  input  logic [DLY_W-1:0] ts,
  input  logic             ovf_clr,
  output logic             sig_out,
  output logic             busy,
  output logic             ovf
);

  localparam int CH_PTR_W = $clog2(EDGE_DEPTH);

  logic                r_s1, r_s2, r_s3;
  logic [DLY_W-1:0]    r_fifo [EDGE_DEPTH];
  logic [CH_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CH_PTR_W:0]   r_count;
  logic [DLY_W-1:0]    r_dly;
  logic                r_sig_out, r_ovf;

  logic                w_edge, w_empty, w_full, w_pop, w_push, w_ovf_set;
  logic [DLY_W-1:0]    w_tgt, w_dly_eff;

  assign w_edge    = r_s2 ^ r_s3;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (CH_PTR_W+1)'(EDGE_DEPTH));
  assign w_tgt     = DLY_W'(target_add(CALC_W'(ts), CALC_W'(r_dly)));
  assign w_dly_eff = DLY_W'(eff_delay(CALC_W'(delay_cfg)));

  // Targets are monotonic and within one counter period of ts, so a plain
  // equality on the head entry is enough to find the due edge.
  assign w_pop     = ch_en && !w_empty && (ts == r_fifo[r_rd_ptr]);
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push    = ch_en && w_edge && (!w_full || w_pop);
  assign w_ovf_set = ch_en && w_edge && w_full && !w_pop;

  // Timestamp storage carries no reset; occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_s3      <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dly     <= DLY_W'(1);
      r_sig_out <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      // Only pick up a new delay while nothing is queued, so queued targets
      // stay in order when delay_cfg changes.
      if (w_empty && !w_push) begin
        r_dly <= w_dly_eff;
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end

      if (!ch_en) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_sig_out <= 1'b0;
      end else if (w_ovf_set) begin
        // Drop the queue and realign the output with the present input level.
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_sig_out <= r_s2;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr  <= r_rd_ptr + 1'b1;
          r_sig_out <= ~r_sig_out;
        end
        r_count <= r_count + (CH_PTR_W+1)'(w_push) - (CH_PTR_W+1)'(w_pop);
      end
    end
  end

  assign sig_out = r_sig_out;
  assign busy    = !w_empty;
  assign ovf     = r_ovf;

endmodule

// File: rtl/delay_cy_mc.sv
// delay_cy_mc
// Multi-channel whole-waveform delay line. A single free-running timestamp is
// shared by NCH independent channel instances.
//   clk, rst   : clock, synchronous active-high reset
//   sig_in     : [NCH] asynchronous input waveforms
//   ch_en      : [NCH] per-channel enable
//   delay_cfg  : [DLY_W] delay in cycles, shared by all channels
//   ovf_clr    : [NCH] write-1-to-clear overflow
//   sig_out    : [NCH] delayed waveforms
//   busy       : [NCH] channel has pending edges
//   ovf        : [NCH] sticky overflow flags
module delay_cy_mc
  import delay_cy_pkg::*;
#(
  parameter int NCH        = DEF_NCH,
  parameter int DLY_W      = DEF_DLY_W,
  parameter int EDGE_DEPTH = DEF_EDGE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   sig_in,
  input  logic [NCH-1:0]   ch_en,
  input  logic [DLY_W-1:0] delay_cfg,
  input  logic [NCH-1:0]   ovf_clr,
  output logic [NCH-1:0]   sig_out,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   ovf
);

  logic [DLY_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      delay_cy_chan #(
        .DLY_W      (DLY_W),
        .EDGE_DEPTH (EDGE_DEPTH)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in[gi]),
        .ch_en     (ch_en[gi]),
        .delay_cfg (delay_cfg),
        .ts        (r_ts),
        .ovf_clr   (ovf_clr[gi]),
        .sig_out   (sig_out[gi]),
        .busy      (busy[gi]),
        .ovf       (ovf[gi])
      );
    end
  endgenerate

endmodule
